// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if
//   Groups the request, ROM and output-stream signals of rom_stream_reader.
//   master : the request issuer, ROM model and stream consumer
//   slave  : the reader itself
//   Signals:
//     start, base_addr, length : burst request (master -> slave)
//     rom_address / rom_data   : synchronous ROM port (address out, data back)
//     out_data/out_valid/out_ready : output stream handshake
//     busy, done               : burst status
interface rom_stream_reader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, length, rom_data, out_ready,
    input  rom_address, out_data, out_valid, busy, done
  );

  modport slave (
    input  start, base_addr, length, rom_data, out_ready,
    output rom_address, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//   Reads a burst of consecutive words from a synchronous ROM (one cycle read
//   latency) and streams them out through a 2-entry buffer with valid/ready
//   flow control. Reads are credit-limited so the buffer can never overflow.
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     rst_n : asynchronous active-low reset, synchronous release
//     bus   : rom_stream_reader_if.slave (request, ROM port, stream, status)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; first read goes out in the accepting cycle
//   READ   | issuing remaining reads as buffer credit allows
//   DRAIN  | all reads issued, waiting for the last word to be accepted
module rom_stream_reader #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  rom_stream_reader_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [2:0]      DEPTH   = 3'(FIFO_DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   len_c;
  logic              inflight;
  logic              start_ok;
  logic              idle_issue;
  logic              read_issue;
  logic              issue;
  logic              done_q;

  logic [DATA_W-1:0] mem [2];
  logic              wr_sel;
  logic              rd_sel;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic              valid_int;
  logic [2:0]        occ_after;

  assign len_c      = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
  assign start_ok   = rst_n && (state == S_IDLE) && bus.start;
  // The first read is launched with the start itself so the first word
  // reaches the output two cycles after start.
  assign idle_issue = start_ok && (len_c != '0);

  assign valid_int  = (count != 2'd0);
  assign pop        = valid_int && bus.out_ready;
  // A word from the ROM lands in the buffer the cycle after its read.
  assign push       = inflight;

  // Occupancy after this cycle's pop, counting the word still in flight.
  // Taking the pop into account keeps one word per cycle flowing with a
  // 2-deep buffer, and still guarantees a full buffer never sees a write.
  assign occ_after  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  assign read_issue = (state == S_READ) && (issue_cnt != '0) && (occ_after < DEPTH);
  assign issue      = idle_issue || read_issue;
  assign issue_addr = (state == S_IDLE) ? bus.base_addr : ptr;

  // Address holds its last issued value between reads.
  assign bus.rom_address = issue ? issue_addr : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      addr_q    <= '0;
      issue_cnt <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (issue) begin
        addr_q <= issue_addr;
        ptr    <= issue_addr + ADDR_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            if (len_c == '0) begin
              done_q <= 1'b1;
            end else begin
              issue_cnt <= len_c - CNT_ONE;
              state     <= (len_c == CNT_ONE) ? S_DRAIN : S_READ;
            end
          end
        end
        S_READ: begin
          if (read_issue) begin
            issue_cnt <= issue_cnt - CNT_ONE;
            if (issue_cnt == CNT_ONE) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && (count == 2'd1) && !inflight) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_sel] <= bus.rom_data;
        wr_sel      <= ~wr_sel;
      end
      if (pop) rd_sel <= ~rd_sel;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_valid = valid_int;
  assign bus.out_data  = mem[rd_sel];
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader
//   Scoreboard bench: each burst pushes the words it should produce (taken
//   straight from the ROM image by address arithmetic) into a queue; a
//   monitor pops and compares on every output handshake.
module tb_rom_stream_reader;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int N  = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] rom [N];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_address];

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  int xfer_cnt = 0;
  int ready_mode = 0;
  int stall_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Consumer: 0 = always ready, 1 = toggle, 2 = random; stall_len forces low.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_len > 0) begin
        bus.out_ready = 1'b0;
        stall_len--;
      end else begin
        case (ready_mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = ~bus.out_ready;
          default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", bus.out_valid, 1);
        check("stall_data_hold", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: actual=%0d required=none", bus.out_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // k counts negedges from the cycle in which start is high (k = 0).
  task automatic burst(input int base, input int len, input int mode, input bit timed,
                       input int stall_at, input int inject_at, input int rst_at_xfer);
    int n, xfer0, first_v, done_k, dones, busy_seen;
    logic [AW-1:0] addr0;
    bit aborted;
    ready_mode = mode;
    n = (len > N) ? N : len;
    for (int i = 0; i < n; i++) exp_q.push_back(rom[(base + i) % N]);
    xfer0 = xfer_cnt;
    first_v = -1; done_k = -1; dones = 0; busy_seen = 0; aborted = 1'b0;
    addr0 = bus.rom_address;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = AW'(base);
    bus.length = (AW+1)'(len);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid && first_v < 0) first_v = k;
      if (bus.busy) busy_seen++;
      if (k == 1) check("busy_after_start", bus.busy, (n > 0) ? 1 : 0);
      if (bus.done) begin
        dones++;
        if (done_k < 0) begin
          done_k = k;
          check("busy_low_at_done", bus.busy, 0);
        end
      end
      if (rst_at_xfer >= 0 && (xfer_cnt - xfer0) == rst_at_xfer) begin
        aborted = 1'b1;
        break;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
      @(posedge clk);
      #1;
      bus.start = (k + 1 == inject_at);
      if (k + 1 == inject_at) begin
        bus.base_addr = AW'(5);
        bus.length = (AW+1)'(3);
      end
      if (k + 1 == stall_at) stall_len = 5;
    end
    bus.start = 1'b0;
    if (aborted) begin
      int v_seen, d_seen;
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_rom_address", bus.rom_address, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ready_mode = 0;
      v_seen = 0; d_seen = 0;
      repeat (12) begin
        @(negedge clk);
        #1;
        if (bus.out_valid) v_seen++;
        if (bus.done) d_seen++;
      end
      check("post_rst_no_valid", v_seen, 0);
      check("post_rst_no_done", d_seen, 0);
    end else begin
      check("done_pulses", dones, 1);
      check("word_count", xfer_cnt - xfer0, n);
      check("words_left", exp_q.size(), 0);
      if (n == 0) begin
        check("len0_done_cycle", done_k, 1);
        check("len0_no_valid", first_v, -1);
        check("len0_busy_never", busy_seen, 0);
        check("len0_addr_hold", bus.rom_address, addr0);
      end else if (timed) begin
        check("first_valid_cycle", first_v, 2);
        check("done_cycle", done_k, n + 2);
      end
      exp_q.delete();
    end
  endtask

  initial begin
    int seed;
    seed = $urandom_range(0, 255);
    // 37 is odd, so the 128 entries are all distinct and any address slip shows.
    for (int i = 0; i < N; i++) rom[i] = DW'(i * 37 + seed);
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_rom_address", bus.rom_address, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    burst(0, 128, 0, 1'b1, -1, -1, -1);   // full ROM, streaming
    burst(120, 16, 2, 1'b0, -1, -1, -1);  // address wrap, random ready
    burst(33, 10, 1, 1'b0, 4, -1, -1);    // toggling ready plus 5-cycle stall
    burst(17, 0, 2, 1'b0, -1, -1, -1);    // zero length
    burst(40, 12, 0, 1'b1, -1, 4, -1);    // start while busy is ignored
    burst(10, 200, 0, 1'b1, -1, -1, -1);  // length clamps to 128
    burst(127, 1, 0, 1'b1, -1, -1, -1);   // single word at top address
    burst(0, 8, 1, 1'b0, -1, -1, 3);      // reset after 3 words
    for (int r = 0; r < 6; r++)
      burst(int'($urandom_range(0, 127)), int'($urandom_range(1, 40)), 2, 1'b0,
            int'($urandom_range(2, 15)), -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
